// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory bus arbiter.
package mem_arb_pkg;

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int MAX_OUTSTANDING_DEFAULT = 2;

endpackage

// File: rtl/arb_owner_fifo.sv
// In-order FIFO of owner IDs, one entry per granted-but-unanswered memory transaction.
module arb_owner_fifo
  import mem_arb_pkg::*;
#(
  parameter int DEPTH = MAX_OUTSTANDING_DEFAULT,
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          srst,
  input  logic          push,
  input  owner_e        push_id,
  input  logic          pop,
  output owner_e        head_id,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  owner_e        slots [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  // Explicit wrap keeps non-power-of-two and depth-1 pointers in range.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_reg == PW'(gi))) begin
        slots[gi] <= push_id;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_id = slots[rd_ptr_reg];
  assign count   = count_reg;
  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin 2:1 arbiter sharing one memory port between fetch and load/store,
// routing in-order responses back to the issuing requester.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT,
  localparam int CW             = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_req,
  input  logic [AW-1:0] instr_addr,
  output logic          instr_gnt,
  output logic          instr_valid,
  output logic [DW-1:0] instr_rdata,
  output logic          instr_err,
  input  logic          data_req,
  input  logic          data_wr,
  input  logic [AW-1:0] data_addr,
  input  logic [DW-1:0] data_wdata,
  input  logic [DW/8-1:0] data_be,
  output logic          data_gnt,
  output logic          data_valid,
  output logic [DW-1:0] data_rdata,
  output logic          data_err,
  output logic          mem_req,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_err,
  output logic          protocol_err
);

  owner_e        last_owner_reg;
  owner_e        head_id;
  logic [CW-1:0] fifo_count;
  logic          fifo_at_cap;
  logic          fifo_empty;
  logic          fifo_full;
  logic          instr_wins;
  logic          handshake;
  logic          pop;
  logic          protocol_err_reg;

  // INSTR takes a tie only when DATA owned the previous handshake.
  assign instr_wins = instr_req & (~data_req | (last_owner_reg == OWNER_DATA));

  // A same-cycle response frees a slot, so a full FIFO still accepts a grant.
  assign fifo_full = (fifo_count == CW'(MAX_OUTSTANDING)) & ~mem_rvalid;
  assign mem_req   = (instr_req | data_req) & ~fifo_full & ~reset;
  assign handshake = mem_req & mem_gnt;

  assign instr_gnt = handshake & instr_wins;
  assign data_gnt  = handshake & ~instr_wins;

  assign mem_wr    = instr_wins ? 1'b0       : data_wr;
  assign mem_addr  = instr_wins ? instr_addr : data_addr;
  assign mem_wdata = instr_wins ? '0         : data_wdata;
  assign mem_be    = instr_wins ? '1         : data_be;

  assign pop = mem_rvalid & ~fifo_empty & ~reset;

  arb_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk     (clk),
    .srst    (reset),
    .push    (handshake & (~fifo_at_cap | pop)),
    .push_id (instr_wins ? OWNER_INSTR : OWNER_DATA),
    .pop     (pop),
    .head_id (head_id),
    .count   (fifo_count),
    .full    (fifo_at_cap),
    .empty   (fifo_empty)
  );

  assign instr_valid = pop & (head_id == OWNER_INSTR);
  assign data_valid  = pop & (head_id == OWNER_DATA);
  assign instr_rdata = mem_rdata;
  assign data_rdata  = mem_rdata;
  assign instr_err   = mem_err;
  assign data_err    = mem_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_reg   <= OWNER_DATA;
      protocol_err_reg <= 1'b0;
    end else begin
      if (handshake) begin
        last_owner_reg <= instr_wins ? OWNER_INSTR : OWNER_DATA;
      end
      if (mem_rvalid && fifo_empty) begin
        protocol_err_reg <= 1'b1;
      end
    end
  end

  assign protocol_err = protocol_err_reg;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic          instr_gnt;
  logic          instr_valid;
  logic [DW-1:0] instr_rdata;
  logic          instr_err;
  logic          data_req;
  logic          data_wr;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW/8-1:0] data_be;
  logic          data_gnt;
  logic          data_valid;
  logic [DW-1:0] data_rdata;
  logic          data_err;
  logic          mem_req;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic          mem_gnt;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;
  logic          mem_err;
  logic          protocol_err;

  int errors = 0;
  int checks = 0;

  mem_bus_arbiter #(
    .AW (AW),
    .DW (DW),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .instr_req    (instr_req),
    .instr_addr   (instr_addr),
    .instr_gnt    (instr_gnt),
    .instr_valid  (instr_valid),
    .instr_rdata  (instr_rdata),
    .instr_err    (instr_err),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_be      (data_be),
    .data_gnt     (data_gnt),
    .data_valid   (data_valid),
    .data_rdata   (data_rdata),
    .data_err     (data_err),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .mem_err      (mem_err),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both sides request every cycle; each response arrives one cycle after its grant.
  task automatic alt_run(input bit first_instr);
    bit exp_instr;
    bit prev_instr;
    prev_instr = 1'b0;
    instr_req = 1'b1; data_req = 1'b1; mem_gnt = 1'b1; data_wr = 1'b0;
    instr_addr = 32'h300; data_addr = 32'h400;
    for (int k = 0; k < 4; k++) begin
      exp_instr  = first_instr ^ k[0];
      mem_rvalid = (k > 0);
      mem_rdata  = 32'hA000_0000 + k;
      #1;
      check("alt_instr_gnt", instr_gnt, exp_instr);
      check("alt_data_gnt", data_gnt, !exp_instr);
      check("alt_mem_addr", mem_addr, exp_instr ? 32'h300 : 32'h400);
      if (k > 0) begin
        check("alt_instr_valid", instr_valid, prev_instr);
        check("alt_data_valid", data_valid, !prev_instr);
        check("alt_rdata", prev_instr ? instr_rdata : data_rdata, 32'hA000_0000 + k);
      end
      prev_instr = exp_instr;
      tick();
    end
    instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hA000_0004;
    #1;
    check("alt_last_instr_valid", instr_valid, prev_instr);
    check("alt_last_data_valid", data_valid, !prev_instr);
    tick();
    mem_rvalid = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    instr_req = 1'b0; instr_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wdata = '0; data_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0;
    tick();
    tick();

    // Outputs stay quiet while reset is high, even with a request and a grant.
    instr_req = 1'b1; mem_gnt = 1'b1;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_instr_gnt", instr_gnt, 1'b0);
    check("rst_protocol_err", protocol_err, 1'b0);
    check("rst_count", dut.u_fifo.count, 0);
    tick();
    reset = 1'b0;

    // Single fetch: grant in cycle 0, response in cycle 1.
    instr_addr = 32'h100;
    #1;
    check("fetch_mem_req", mem_req, 1'b1);
    check("fetch_instr_gnt", instr_gnt, 1'b1);
    check("fetch_data_gnt", data_gnt, 1'b0);
    check("fetch_mem_addr", mem_addr, 32'h100);
    check("fetch_mem_wr", mem_wr, 1'b0);
    check("fetch_mem_be", mem_be, 4'hF);
    check("fetch_mem_wdata", mem_wdata, 32'h0);
    tick();
    instr_req = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    check("fetch_instr_valid", instr_valid, 1'b1);
    check("fetch_instr_rdata", instr_rdata, 32'hDEADBEEF);
    check("fetch_data_valid", data_valid, 1'b0);
    tick();
    mem_rvalid = 1'b0;

    // INSTR owned the last handshake, so DATA wins the first tie here.
    alt_run(1'b0);

    // Fill both slots with memory silent, then free one with a same-cycle response.
    instr_req = 1'b1; instr_addr = 32'h500; mem_gnt = 1'b1;
    #1;
    check("full_g1_instr_gnt", instr_gnt, 1'b1);
    tick();
    instr_req = 1'b0; data_req = 1'b1; data_addr = 32'h600; data_wr = 1'b0;
    #1;
    check("full_g2_data_gnt", data_gnt, 1'b1);
    tick();
    #1;
    check("full_count", dut.u_fifo.count, 2);
    check("full_mem_req", mem_req, 1'b0);
    check("full_data_gnt", data_gnt, 1'b0);
    mem_rvalid = 1'b1; mem_rdata = 32'hB1;
    #1;
    check("full_pop_mem_req", mem_req, 1'b1);
    check("full_pop_data_gnt", data_gnt, 1'b1);
    check("full_pop_instr_valid", instr_valid, 1'b1);
    check("full_pop_data_valid", data_valid, 1'b0);
    tick();
    data_req = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'hB2;
    #1;
    check("drain1_data_valid", data_valid, 1'b1);
    check("drain1_data_rdata", data_rdata, 32'hB2);
    tick();
    mem_rdata = 32'hB3;
    #1;
    check("drain2_data_valid", data_valid, 1'b1);
    tick();
    mem_rvalid = 1'b0;
    #1;
    check("drain_count", dut.u_fifo.count, 0);

    // Store with partial byte enables and an error response.
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h200; data_be = 4'b0011;
    data_wdata = 32'h1234; mem_gnt = 1'b1;
    #1;
    check("store_data_gnt", data_gnt, 1'b1);
    check("store_mem_wr", mem_wr, 1'b1);
    check("store_mem_be", mem_be, 4'b0011);
    check("store_mem_wdata", mem_wdata, 32'h1234);
    check("store_mem_addr", mem_addr, 32'h200);
    tick();
    data_req = 1'b0; data_wr = 1'b0; mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h0;
    #1;
    check("store_data_valid", data_valid, 1'b1);
    check("store_data_err", data_err, 1'b1);
    check("store_instr_valid", instr_valid, 1'b0);
    tick();
    mem_rvalid = 1'b0; mem_err = 1'b0;

    // Stray response with nothing outstanding.
    mem_rvalid = 1'b1; mem_rdata = 32'hBAD;
    #1;
    check("stray_instr_valid", instr_valid, 1'b0);
    check("stray_data_valid", data_valid, 1'b0);
    tick();
    mem_rvalid = 1'b0;
    #1;
    check("stray_protocol_err", protocol_err, 1'b1);
    tick();
    tick();
    check("stray_protocol_err_sticky", protocol_err, 1'b1);

    // Two outstanding, then reset mid-operation.
    instr_req = 1'b1; data_req = 1'b1; instr_addr = 32'h700; data_addr = 32'h800;
    mem_gnt = 1'b1;
    #1;
    check("pre_rst_instr_gnt", instr_gnt, 1'b1);
    tick();
    check("pre_rst_data_gnt", data_gnt, 1'b1);
    tick();
    check("pre_rst_mem_req", mem_req, 1'b0);
    reset = 1'b1; mem_rvalid = 1'b1;
    #1;
    check("in_rst_mem_req", mem_req, 1'b0);
    check("in_rst_gnts", {instr_gnt, data_gnt}, 2'b00);
    check("in_rst_valids", {instr_valid, data_valid}, 2'b00);
    tick();
    reset = 1'b0; instr_req = 1'b0; data_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    check("post_rst_count", dut.u_fifo.count, 0);
    check("post_rst_protocol_err", protocol_err, 1'b0);
    check("post_rst_gnts", {instr_gnt, data_gnt}, 2'b00);
    check("post_rst_valids", {instr_valid, data_valid}, 2'b00);

    // Fresh arbitration after reset: INSTR wins the first tie.
    alt_run(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
